// File: rtl/cpu_core_p.sv
// cpu_core_p: parametrised multi-cycle simple-RISC core.
//
// Executes one 16-bit instruction at a time from an eight-entry register
// file of DATA_W-bit registers. Instructions are MOV imm, MOV shift, ADD,
// CMP, AND and MVN. Any other opcode/op pair sets the sticky ill flag.
//
// Parameters:
//   DATA_W   - register/datapath width (16..64)
//   SH_AMT   - shift distance used by shift codes 01/10/11
//   ASR_EN   - 1: shift code 11 is arithmetic right, 0: logical right
//   FLAG_ALL - 0: only CMP writes N/V/Z, 1: ADD/AND/MVN write them too
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   s         start request (sampled only in WAIT)
//   load      instruction register load enable (effective only in WAIT)
//   in        instruction word
//   out       C (result) register
//   N, V, Z   status flags
//   w         high while the core is in WAIT
//   ill       sticky illegal-opcode indicator
//   dbg_state current FSM state encoding
//
// Handshake: the core is idle exactly when w=1. On a rising edge with w=1,
// load=1 captures in into IR and s=1 starts the instruction held in IR
// after that capture. While w=0, s and load are ignored. If s stays high,
// the next instruction starts on the edge after the core returns to WAIT.
module cpu_core_p #(
    parameter int DATA_W   = 16,
    parameter int SH_AMT   = 1,
    parameter int ASR_EN   = 1,
    parameter int FLAG_ALL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              ill,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_RDA    = 3'd2,
        S_RDB    = 3'd3,
        S_EXEC   = 3'd4,
        S_WB     = 3'd5,
        S_CMPS   = 3'd6,
        S_WIMM   = 3'd7
    } state_t;

    localparam int MSB = DATA_W - 1;

    state_t            state;
    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [15:0]       ir;

    // Instruction fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    logic is_mov_imm;
    logic is_mov_sh;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_sh  = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = {{(DATA_W-8){ir[7]}}, ir[7:0]};

    // Shifter on the B operand
    logic [DATA_W-1:0] sh_b;
    always_comb begin
        sh_b = b;
        case (sh)
            2'b01:   sh_b = b << SH_AMT;
            2'b10:   sh_b = b >> SH_AMT;
            2'b11:   sh_b = (ASR_EN != 0) ? $unsigned($signed(b) >>> SH_AMT)
                                          : (b >> SH_AMT);
            default: sh_b = b;
        endcase
    end

    // ALU; MOV shift relies on A having been cleared, so 0 + sh(B)
    logic [DATA_W-1:0] alu_res;
    always_comb begin
        alu_res = a + sh_b;
        if (is_alu) begin
            case (op)
                2'b01:   alu_res = a - sh_b;
                2'b10:   alu_res = a & sh_b;
                2'b11:   alu_res = ~sh_b;
                default: alu_res = a + sh_b;
            endcase
        end
    end

    logic res_n;
    logic res_z;
    logic res_v;
    always_comb begin
        res_n = alu_res[MSB];
        res_z = (alu_res == '0);
        res_v = 1'b0;
        if (is_alu && op == 2'b00)
            res_v = (a[MSB] == sh_b[MSB]) && (alu_res[MSB] != a[MSB]);
        else if (is_alu && op == 2'b01)
            res_v = (a[MSB] != sh_b[MSB]) && (alu_res[MSB] != a[MSB]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_WAIT;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            a   <= '0;
            b   <= '0;
            c   <= '0;
            ir  <= '0;
            N   <= 1'b0;
            V   <= 1'b0;
            Z   <= 1'b0;
            ill <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_mov_imm) begin
                        ill   <= 1'b0;
                        state <= S_WIMM;
                    end else if (is_mov_sh || is_mvn) begin
                        ill   <= 1'b0;
                        a     <= '0;
                        state <= S_RDB;
                    end else if (is_alu) begin
                        ill   <= 1'b0;
                        state <= S_RDA;
                    end else begin
                        ill   <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_RDA: begin
                    a     <= rf[rn];
                    state <= S_RDB;
                end
                S_RDB: begin
                    b     <= rf[rm];
                    state <= is_cmp ? S_CMPS : S_EXEC;
                end
                S_EXEC: begin
                    c <= alu_res;
                    if (FLAG_ALL != 0 && is_alu) begin
                        N <= res_n;
                        V <= res_v;
                        Z <= res_z;
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    rf[rd] <= c;
                    state  <= S_WAIT;
                end
                S_CMPS: begin
                    N     <= res_n;
                    V     <= res_v;
                    Z     <= res_z;
                    state <= S_WAIT;
                end
                S_WIMM: begin
                    rf[rn] <= imm_ext;
                    state  <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign out       = c;
    assign w         = (state == S_WAIT);
    assign dbg_state = state;

endmodule

// File: tb/tb_cpu_core_p.sv
// tb_cpu_core_p: directed testbench for cpu_core_p.
//
// Four instances share one instruction stream (latency does not depend on
// the parameters): u0 default, u1 ASR_EN=0, u2 DATA_W=32/SH_AMT=4,
// u3 FLAG_ALL=1. Each test task drives instructions and checks the relevant
// instance against hand-computed values.
module tb_cpu_core_p;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] instr;

    logic [15:0] out0, out1, out3;
    logic [31:0] out2;
    logic        n0, v0, z0, w0, ill0;
    logic        n1, v1, z1, w1, ill1;
    logic        n2, v2, z2, w2, ill2;
    logic        n3, v3, z3, w3, ill3;
    logic [2:0]  st0, st1, st2, st3;

    int tests_run    = 0;
    int tests_failed = 0;
    int lat;

    cpu_core_p u0 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(instr),
        .out(out0), .N(n0), .V(v0), .Z(z0), .w(w0), .ill(ill0), .dbg_state(st0)
    );
    cpu_core_p #(.ASR_EN(0)) u1 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(instr),
        .out(out1), .N(n1), .V(v1), .Z(z1), .w(w1), .ill(ill1), .dbg_state(st1)
    );
    cpu_core_p #(.DATA_W(32), .SH_AMT(4)) u2 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(instr),
        .out(out2), .N(n2), .V(v2), .Z(z2), .w(w2), .ill(ill2), .dbg_state(st2)
    );
    cpu_core_p #(.FLAG_ALL(1)) u3 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(instr),
        .out(out3), .N(n3), .V(v3), .Z(z3), .w(w3), .ill(ill3), .dbg_state(st3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: start one instruction (called just after a rising edge) and
    // return the number of edges until w is high again, bounded at 20.
    task automatic run_instr(input logic [15:0] i_word, output int n);
        instr = i_word;
        load  = 1'b1;
        s     = 1'b1;
        @(posedge clk); #1;
        load  = 1'b0;
        s     = 1'b0;
        n     = 1;
        while (!w0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests_run++; if (out0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_out: got %h exp 0000", out0); end
        tests_run++; if ({n0, v0, z0} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b exp 000", {n0, v0, z0}); end
        tests_run++; if (w0 !== 1'b1) begin tests_failed++; $display("FAIL reset_w: got %b exp 1", w0); end
        tests_run++; if (ill0 !== 1'b0) begin tests_failed++; $display("FAIL reset_ill: got %b exp 0", ill0); end
        tests_run++; if (st0 !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d exp 0", st0); end
        tests_run++; if (out2 !== 32'h0) begin tests_failed++; $display("FAIL reset_out32: got %h exp 0", out2); end
    endtask

    task automatic test_add();
        run_instr(16'hD007, lat);   // MOV R0,#7
        tests_run++; if (lat !== 3) begin tests_failed++; $display("FAIL lat_mov_imm: got %0d exp 3", lat); end
        run_instr(16'hD102, lat);   // MOV R1,#2
        run_instr(16'hA041, lat);   // ADD R2,R0,R1
        tests_run++; if (lat !== 6) begin tests_failed++; $display("FAIL lat_add: got %0d exp 6", lat); end
        tests_run++; if (out0 !== 16'h0009) begin tests_failed++; $display("FAIL add_out: got %h exp 0009", out0); end
        tests_run++; if (w0 !== 1'b1) begin tests_failed++; $display("FAIL add_w: got %b exp 1", w0); end
        tests_run++; if (out2 !== 32'h9) begin tests_failed++; $display("FAIL add_out32: got %h exp 00000009", out2); end
        tests_run++; if ({n0, v0, z0} !== 3'b000) begin tests_failed++; $display("FAIL add_noflags: got %b exp 000", {n0, v0, z0}); end
    endtask

    task automatic test_shift();
        run_instr(16'hD4FF, lat);   // MOV R4,#0xFF -> 0xFFFF
        run_instr(16'hC0A4, lat);   // MOV R5,R4
        tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL lat_mov_sh: got %0d exp 5", lat); end
        tests_run++; if (out0 !== 16'hFFFF) begin tests_failed++; $display("FAIL sext_imm: got %h exp ffff", out0); end
        run_instr(16'hC0CC, lat);   // MOV R6,R4,LSL
        tests_run++; if (out0 !== 16'hFFFE) begin tests_failed++; $display("FAIL lsl: got %h exp fffe", out0); end
        run_instr(16'hC0D4, lat);   // MOV R6,R4,LSR
        tests_run++; if (out0 !== 16'h7FFF) begin tests_failed++; $display("FAIL lsr: got %h exp 7fff", out0); end
        run_instr(16'hC0FC, lat);   // MOV R7,R4,ASR
        tests_run++; if (out0 !== 16'hFFFF) begin tests_failed++; $display("FAIL asr_on: got %h exp ffff", out0); end
        tests_run++; if (out1 !== 16'h7FFF) begin tests_failed++; $display("FAIL asr_off: got %h exp 7fff", out1); end
        tests_run++; if (out2 !== 32'hFFFFFFFF) begin tests_failed++; $display("FAIL asr32: got %h exp ffffffff", out2); end
    endtask

    task automatic test_cmp();
        run_instr(16'hD201, lat);   // MOV R2,#1
        run_instr(16'hD107, lat);   // MOV R1,#7
        run_instr(16'hAA01, lat);   // CMP R2,R1 : 1-7
        tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL lat_cmp: got %0d exp 5", lat); end
        tests_run++; if ({n0, v0, z0} !== 3'b100) begin tests_failed++; $display("FAIL cmp_neg: got NVZ=%b exp 100", {n0, v0, z0}); end
        tests_run++; if (out0 !== 16'hFFFF) begin tests_failed++; $display("FAIL cmp_out_kept: got %h exp ffff", out0); end
        run_instr(16'hA800, lat);   // CMP R0,R0
        tests_run++; if ({n0, v0, z0} !== 3'b001) begin tests_failed++; $display("FAIL cmp_eq: got NVZ=%b exp 001", {n0, v0, z0}); end
        run_instr(16'hAE04, lat);   // CMP R6,R4 : 7FFF - FFFF
        tests_run++; if ({n0, v0, z0} !== 3'b110) begin tests_failed++; $display("FAIL cmp_ovf: got NVZ=%b exp 110", {n0, v0, z0}); end
    endtask

    task automatic test_wide();
        run_instr(16'hD101, lat);   // MOV R1,#1
        run_instr(16'hA169, lat);   // ADD R3,R1,R1,LSL
        tests_run++; if (out2 !== 32'h00000011) begin tests_failed++; $display("FAIL wide_add: got %h exp 00000011", out2); end
        tests_run++; if (out0 !== 16'h0003) begin tests_failed++; $display("FAIL add_lsl16: got %h exp 0003", out0); end
        run_instr(16'hB8A1, lat);   // MVN R5,R1
        tests_run++; if (out2 !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL wide_mvn: got %h exp fffffffe", out2); end
        tests_run++; if (out0 !== 16'hFFFE) begin tests_failed++; $display("FAIL mvn16: got %h exp fffe", out0); end
        tests_run++; if ({n3, v3, z3} !== 3'b100) begin tests_failed++; $display("FAIL mvn_flags_all: got NVZ=%b exp 100", {n3, v3, z3}); end
    endtask

    task automatic test_illegal();
        run_instr(16'hE000, lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL lat_ill: got %0d exp 2", lat); end
        tests_run++; if (ill0 !== 1'b1) begin tests_failed++; $display("FAIL ill_set: got %b exp 1", ill0); end
        tests_run++; if ({n0, v0, z0} !== 3'b110) begin tests_failed++; $display("FAIL ill_flags_kept: got NVZ=%b exp 110", {n0, v0, z0}); end
        tests_run++; if (out0 !== 16'hFFFE) begin tests_failed++; $display("FAIL ill_out_kept: got %h exp fffe", out0); end
        // MOV R2,#3 stepped by hand to watch ill clear at the DECODE edge
        instr = 16'hD203; load = 1'b1; s = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        tests_run++; if (ill0 !== 1'b1) begin tests_failed++; $display("FAIL ill_held_decode: got %b exp 1", ill0); end
        @(posedge clk); #1;
        tests_run++; if (ill0 !== 1'b0) begin tests_failed++; $display("FAIL ill_clear: got %b exp 0", ill0); end
        tests_run++; if (st0 !== 3'd7) begin tests_failed++; $display("FAIL wimm_state: got %0d exp 7", st0); end
        @(posedge clk); #1;
        tests_run++; if (w0 !== 1'b1) begin tests_failed++; $display("FAIL wimm_return: got %b exp 1", w0); end
    endtask

    task automatic test_back_to_back();
        instr = 16'hD312; load = 1'b1; s = 1'b1;   // MOV R3,#0x12
        @(posedge clk); #1;
        instr = 16'hE000;                          // must be ignored outside WAIT
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++; if (w0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_wait: got %b exp 1", w0); end
        instr = 16'hC023;                          // MOV R1,R3
        @(posedge clk); #1;
        tests_run++; if (w0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_restart: got %b exp 0", w0); end
        load = 1'b0; s = 1'b0;
        lat = 1;
        while (!w0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat !== 5) begin tests_failed++; $display("FAIL b2b_lat: got %0d exp 5", lat); end
        tests_run++; if (out0 !== 16'h0012) begin tests_failed++; $display("FAIL b2b_out: got %h exp 0012", out0); end
        run_instr(16'hC0A0, lat);   // MOV R5,R0 : R0 untouched since test_add
        tests_run++; if (out0 !== 16'h0007) begin tests_failed++; $display("FAIL r0_kept: got %h exp 0007", out0); end
    endtask

    task automatic test_reset_abort();
        instr = 16'hA041; load = 1'b1; s = 1'b1;   // ADD R2,R0,R1
        @(posedge clk); #1;
        load = 1'b0; s = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tests_run++; if (st0 !== 3'd4) begin tests_failed++; $display("FAIL abort_in_exec: got %0d exp 4", st0); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        tests_run++; if (w0 !== 1'b1) begin tests_failed++; $display("FAIL abort_w: got %b exp 1", w0); end
        tests_run++; if (out0 !== 16'h0000) begin tests_failed++; $display("FAIL abort_out: got %h exp 0000", out0); end
        tests_run++; if ({n0, v0, z0} !== 3'b000) begin tests_failed++; $display("FAIL abort_flags: got %b exp 000", {n0, v0, z0}); end
        run_instr(16'hC0C2, lat);   // MOV R6,R2
        tests_run++; if (out0 !== 16'h0000) begin tests_failed++; $display("FAIL abort_r2: got %h exp 0000", out0); end
    endtask

    task automatic test_flag_all();
        run_instr(16'hD0FF, lat);   // MOV R0,#0xFF
        run_instr(16'hC030, lat);   // MOV R1,R0,LSR -> 7FFF
        tests_run++; if (out3 !== 16'h7FFF) begin tests_failed++; $display("FAIL fa_mov: got %h exp 7fff", out3); end
        tests_run++; if ({n3, v3, z3} !== 3'b000) begin tests_failed++; $display("FAIL fa_mov_noflags: got %b exp 000", {n3, v3, z3}); end
        run_instr(16'hD201, lat);   // MOV R2,#1
        run_instr(16'hA162, lat);   // ADD R3,R1,R2 : 7FFF+1
        tests_run++; if (out3 !== 16'h8000) begin tests_failed++; $display("FAIL fa_add: got %h exp 8000", out3); end
        tests_run++; if ({n3, v3, z3} !== 3'b110) begin tests_failed++; $display("FAIL fa_add_ovf: got NVZ=%b exp 110", {n3, v3, z3}); end
        tests_run++; if ({n0, v0, z0} !== 3'b000) begin tests_failed++; $display("FAIL default_add_noflags: got %b exp 000", {n0, v0, z0}); end
        run_instr(16'hB1A0, lat);   // AND R5,R1,R0
        tests_run++; if ({n3, v3, z3} !== 3'b000) begin tests_failed++; $display("FAIL fa_and: got NVZ=%b exp 000", {n3, v3, z3}); end
        run_instr(16'hA082, lat);   // ADD R4,R0,R2 : FFFF+1
        tests_run++; if ({n3, v3, z3} !== 3'b001) begin tests_failed++; $display("FAIL fa_add_zero: got NVZ=%b exp 001", {n3, v3, z3}); end
    endtask

    initial begin
        reset = 1'b0;
        s     = 1'b0;
        load  = 1'b0;
        instr = 16'h0000;
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_shift();
        test_cmp();
        test_wide();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_flag_all();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_core_p.md
# cpu_core_p

Parametrised multi-cycle core: a successor to the fixed 16-bit simple-RISC `cpu`. It keeps the 16-bit instruction encoding and the eight-register file, and the same `s`/`load`/`w` start handshake. New relative to `cpu`:
- data width is a parameter;
- shift distance is a parameter;
- arithmetic shift right is a selectable mode;
- flag update can be enabled on all ALU operations;
- illegal opcodes are reported.

The block sits between the instruction source (testbench or fetch unit) and the board I/O wrapper.

## Interface
- DATA_W, 16: datapath/register width; legal range 16..64.
- SH_AMT, 1: shift distance for shift codes 01/10/11; legal range 1..DATA_W-1.
- ASR_EN, 1: 1 = shift code 11 is arithmetic right; 0 = code 11 behaves as code 10 (logical right).
- FLAG_ALL, 0: 0 = only CMP writes N/V/Z; 1 = ADD, AND and MVN also write flags.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled on rising `clk`.
- s  in  1  start request; level-sampled only in WAIT.
- load  in  1  instruction-register load enable; effective only in WAIT.
- in  in  16  instruction word.
- out  out  DATA_W  C (result) register.
- N, V, Z  out  1 each  status register bits.
- w  out  1  high exactly while in WAIT.
- ill  out  1  sticky illegal-opcode indicator.

## Operation
Encoding:
- [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.

Instructions:
- 110/10 MOV Rn,#imm8: Rn = imm8 sign-extended to DATA_W.
- 110/00 MOV Rd,Rm,sh: Rd = sh(Rm).
- 101/00 ADD: Rd = Rn + sh(Rm).
- 101/01 CMP: compute Rn - sh(Rm); write flags only.
- 101/10 AND: Rd = Rn & sh(Rm).
- 101/11 MVN: Rd = ~sh(Rm).
- Any other opcode/op pair is illegal.

Shift codes, all by SH_AMT:
- 00: none.
- 01: logical left, zero fill.
- 10: logical right, zero fill.
- 11: arithmetic right (MSB replicated) if ASR_EN=1, otherwise as 10.

Arithmetic:
- All arithmetic is modulo 2^DATA_W.
- N = result[DATA_W-1].
- Z = (result == 0).
- V (CMP) = signed overflow of A-B, i.e. A[msb] != B[msb] and result[msb] != A[msb].
- V (ADD with FLAG_ALL=1) = A[msb] == B[msb] and result[msb] != A[msb].
- AND and MVN with FLAG_ALL=1 clear V.

States and transitions:
- WAIT: `w`=1. If load=1, IR <= in. If s=1, go to DECODE (IR as loaded on that same edge); otherwise stay.
- DECODE:
  - MOV imm -> WIMM.
  - ADD/AND/CMP -> RDA.
  - MOV shift/MVN -> RDB.
  - Illegal -> WAIT with ill<=1.
  - Any legal instruction clears ill at this edge.
- RDA: A <= R[Rn]; -> RDB.
- RDB: B <= R[Rm]; -> EXEC for non-CMP, -> CMPS for CMP.
  - MOV shift/MVN use A=0; A is cleared on entry to RDB from DECODE.
- EXEC: C <= ALU result (MOV shift computes 0 + sh(B)); flags updated if FLAG_ALL=1 and op is not MOV. -> WB.
- WB: R[Rd] <= C; -> WAIT.
- CMPS: N/V/Z <= flags of A - sh(B); C unchanged. -> WAIT.
- WIMM: R[Rn] <= sext(imm8); C and flags unchanged. -> WAIT.

Rules:
- `s` and `load` are ignored outside WAIT.
- If `s` is still high on return to WAIT, the next instruction starts on the following edge.
- Exactly one register write per instruction, none for CMP or illegal.

## Timing
- Reset (reset==0 at a rising edge):
  - state=WAIT, w=1;
  - R0..R7, A, B, C, IR = 0;
  - out=0, N=V=Z=0, ill=0.
  - Reset overrides everything; an in-flight instruction is aborted and no write occurs on the reset edge.
- Latency, counted as edges from the edge that samples s=1 in WAIT to the edge that re-enters WAIT:
  - MOV imm: 3;
  - MOV shift, MVN: 5;
  - ADD, AND: 6;
  - CMP: 5;
  - illegal: 2.
- `out` changes only at the EXEC edge.
- Flags change only at the CMPS edge, or the EXEC edge when FLAG_ALL=1.
- Register-file results are visible to the next instruction's RDA/RDB; there are no hazards, since execution is strictly sequential.

## Test plan
1. Default params: MOV R0,#7; MOV R1,#2; ADD R2,R0,R1 -> out=9 on the 6th edge after start, w=1 on return to WAIT.
2. MOV R4,#0xFF -> R4=0xFFFF. Then:
   - MOV R7,R4 with sh=11, ASR_EN=1 -> out=0xFFFF.
   - Same with ASR_EN=0 -> out=0x7FFF.
3. CMP with R2=1, R1=7 -> Z=0, N=1, V=0, out unchanged. CMP R0,R0 -> Z=1, N=0, V=0.
4. DATA_W=32, SH_AMT=4: MOV R1,#1; ADD R3,R1,R1 with sh=01 -> out=0x00000011. MVN R5,R1 -> out=0xFFFFFFFE.
5. Instruction 0xE000 -> ill=1 after 2 edges, no register or flag change. A following legal MOV clears ill at its DECODE edge.
6. Drive reset=0 while in EXEC of ADD -> next edge: state WAIT, out=0, flags 0, target register 0. FLAG_ALL=1 ADD of 0x7FFF+1 (DATA_W=16) -> V=1, N=1, Z=0.
